// File: rtl/key_event_scheduler_pkg.sv
// Shared types and constants for the keypad event scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package key_event_scheduler_pkg;

    localparam int DEF_KEYS_NUM   = 4;
    localparam int DEF_SAMPLE_DIV = 100000;
    localparam int DEF_REP_DIV    = 25;

    // Two-bit encoding leaves spare codes; any of them recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OFFER = 2'b01
    } state_t;

    // Width of the key index carried on the event channel.
    function automatic int code_w(input int keys);
        return (keys < 2) ? 1 : $clog2(keys);
    endfunction

endpackage

// File: rtl/key_event_scheduler_if.sv
// Event channel between debouncer bank, scheduler and timer control FSM.
// Latency: n/a (wires only).
// Backpressure: ev_vld holds until ev_ack; ev_code is stable while ev_vld is high.
interface key_event_scheduler_if
    import key_event_scheduler_pkg::*;
#(
    parameter int KEYS_NUM = DEF_KEYS_NUM
);
    localparam int CW = code_w(KEYS_NUM);

    logic                en;
    logic [KEYS_NUM-1:0] key_up;
    logic [KEYS_NUM-1:0] key_en;
    logic                sample_ce;
    logic                rep_ce;
    logic                ev_vld;
    logic [CW-1:0]       ev_code;
    logic                ev_ack;
    logic                overrun;
    logic                ovr_clr;

    // Scheduler side.
    modport master (
        input  en, key_up, key_en, ev_ack, ovr_clr,
        output sample_ce, rep_ce, ev_vld, ev_code, overrun
    );

    // Debouncer bank / consumer side.
    modport slave (
        output en, key_up, key_en, ev_ack, ovr_clr,
        input  sample_ce, rep_ce, ev_vld, ev_code, overrun
    );

endinterface

// File: rtl/key_event_scheduler_tick_presc.sv
// Modulo-N prescaler: one-cycle ceo_o on the last count of each enabled period.
// Latency: ceo_o is combinational from the registered count and ce_i.
// Backpressure: none; the count holds while ce_i is low.
module tick_presc #(
    parameter int N = 4
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic ce_i,
    output logic ceo_o
);
    localparam int            W    = (N < 2) ? 1 : $clog2(N);
    localparam logic [W-1:0]  LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign ceo_o = ce_i & (cnt_q == LAST);

    // Advance on enable, wrap after the last count.
    always_comb begin
        cnt_d = cnt_q;
        if (ce_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/key_event_scheduler.sv
// Keypad front end: debouncer strobes plus round-robin arbitration of key events.
// Latency: KEY_UP at t -> pending at t+1 -> ev_vld at t+2; one event per 2 cycles max.
// Backpressure: offer held until ev_ack; a key re-firing while still pending sets overrun.
module key_event_scheduler
    import key_event_scheduler_pkg::*;
#(
    parameter int KEYS_NUM   = DEF_KEYS_NUM,
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int REP_DIV    = DEF_REP_DIV
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    key_event_scheduler_if.master  bus
);
    localparam int CW = code_w(KEYS_NUM);

    typedef logic [KEYS_NUM-1:0] kvec_t;

    // First requesting key at or above start, searching modulo KEYS_NUM.
    function automatic logic [CW-1:0] rr_pick(input kvec_t req, input logic [CW-1:0] start);
        logic [CW-1:0] pick;
        logic [CW-1:0] idx;
        logic          found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < KEYS_NUM; k++) begin
            idx = CW'((int'(start) + k) % KEYS_NUM);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    state_t        state_q, state_d;
    kvec_t         pend_q, pend_d;
    logic [CW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] code_q, code_d;
    logic          ovr_q, ovr_d;

    logic          smp_ce;
    logic          rep_wrap;
    logic          chord;
    logic [CW:0]   held_cnt;
    logic          grant_vld;
    logic [CW-1:0] grant_idx;
    kvec_t         grant_mask;
    logic          ovr_set;
    logic          ev_vld;

    // Strobe generation: sample divider on EN, repeat divider on each sample strobe.
    tick_presc #(.N(SAMPLE_DIV)) u_smp_presc (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .ce_i  (bus.en),
        .ceo_o (smp_ce)
    );

    tick_presc #(.N(REP_DIV)) u_rep_presc (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .ce_i  (smp_ce),
        .ceo_o (rep_wrap)
    );

    // Count held keys; two or more held is a chord and mutes auto-repeat.
    always_comb begin
        held_cnt = '0;
        for (int k = 0; k < KEYS_NUM; k++) begin
            held_cnt = held_cnt + (CW+1)'(bus.key_en[k]);
        end
    end

    assign chord = (held_cnt >= (CW+1)'(2));

    // The repeat divider keeps advancing during a chord; only the strobe is masked.
    assign bus.sample_ce = smp_ce;
    assign bus.rep_ce    = rep_wrap & ~chord;

    // Grant is taken only from IDLE, so at most one key is cleared per cycle.
    assign grant_vld  = (state_q == ST_IDLE) && (pend_q != '0);
    assign grant_idx  = rr_pick(pend_q, ptr_q);
    assign grant_mask = grant_vld ? (kvec_t'(1) << grant_idx) : '0;

    // A key firing while its earlier event is still waiting loses that event.
    assign ovr_set = |(bus.key_up & pend_q & ~grant_mask);

    // Pending/overrun next state: new pulses win over the grant clear and OVR_CLR.
    always_comb begin
        pend_d = (pend_q & ~grant_mask) | bus.key_up;
        ovr_d  = ovr_q;
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (bus.ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    // Latch the granted code; advance the round-robin pointer once the offer is taken.
    always_comb begin
        code_d = code_q;
        ptr_d  = ptr_q;
        if (grant_vld) begin
            code_d = grant_idx;
        end
        if ((state_q == ST_OFFER) && bus.ev_ack) begin
            ptr_d = (code_q == CW'(KEYS_NUM - 1)) ? '0 : code_q + 1'b1;
        end
    end

    // Next-state logic: IDLE grants, OFFER waits for the consumer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant_vld)  state_d = ST_OFFER;
            ST_OFFER: if (bus.ev_ack) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Output decode: an event is offered exactly while in OFFER.
    always_comb begin
        ev_vld = 1'b0;
        if (state_q == ST_OFFER) begin
            ev_vld = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: pending set, pointer, offered code, sticky overrun.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
            ptr_q  <= '0;
            code_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ptr_q  <= ptr_d;
            code_q <= code_d;
            ovr_q  <= ovr_d;
        end
    end

    assign bus.ev_vld  = ev_vld;
    assign bus.ev_code = code_q;
    assign bus.overrun = ovr_q;

endmodule
